// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the seven-segment scan capture.
package seg_scan_pkg;
  localparam int DIGITS = 8;
  // Active-low gfedcba patterns, index = hex value.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {SYNC, CAPTURE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment pattern to hex nibble, flags unknown patterns.
module seg7_decode import seg_scan_pkg::*; (
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       invalid
);
  always_comb begin
    nibble = '0;
    invalid = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg == SEG_PAT[i]) begin
        nibble = 4'(i);
        invalid = 1'b0;
      end
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: filters, decodes and reassembles 8-digit multiplexed display frames.
// Define SEGCAP_SYNC_EN to add a two-flop synchronizer ahead of the input register.
module seg_scan_capture import seg_scan_pkg::*; #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        seg_err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [7:0] an_i, an_r, an_p;
  logic [6:0] seg_i, seg_r, seg_p;
  logic [CW-1:0] cnt;
  logic taken, match, accept, multi, invalid, wrong;
  logic [2:0] idx, expect_idx;
  logic [3:0] nibble;
  logic [31:0] asm_r;
  state_t state;
`ifdef SEGCAP_SYNC_EN
  logic [7:0] an_s1, an_s2;
  logic [6:0] seg_s1, seg_s2;
  always_ff @(posedge clk)
    if (rst) {an_s1, an_s2, seg_s1, seg_s2} <= {8'hFF, 8'hFF, 7'h7F, 7'h7F};
    else {an_s1, an_s2, seg_s1, seg_s2} <= {an, an_s1, seg, seg_s1};
  assign an_i = an_s2;
  assign seg_i = seg_s2;
`else
  assign an_i = an;
  assign seg_i = seg;
`endif
  assign match = {an_r, seg_r} == {an_p, seg_p};
  assign accept = match && cnt == CW'(STABLE_CYCLES - 1) && !taken && an_r != 8'hFF;
  assign multi = |(~an_r & (~an_r - 8'd1));
  assign wrong = multi || (state == CAPTURE && idx != expect_idx);
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_r[i]) idx = 3'(i);
  end
  seg7_decode u_dec (.seg(seg_r), .nibble(nibble), .invalid(invalid));
  // taken blocks re-acceptance until the strobe moves to another digit
  always_ff @(posedge clk)
    if (rst) begin
      {an_r, an_p, seg_r, seg_p} <= {8'hFF, 8'hFF, 7'h7F, 7'h7F};
      cnt <= '0;
      taken <= 1'b0;
    end else begin
      {an_r, an_p, seg_r, seg_p} <= {an_i, an_r, seg_i, seg_r};
      cnt <= !match ? '0 : cnt == CW'(STABLE_CYCLES - 1) ? cnt : cnt + 1'b1;
      taken <= accept || (taken && an_r == an_p);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= SYNC;
      expect_idx <= 3'd7;
      asm_r <= '0;
      value <= '0;
      frame_valid <= 1'b0;
      seq_err <= 1'b0;
      seg_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      seq_err <= 1'b0;
      seg_err <= 1'b0;
      if (accept) begin
        if (wrong) begin
          seq_err <= 1'b1;
          state <= SYNC;
        end else if (invalid) begin
          seg_err <= 1'b1;
          state <= SYNC;
        end else if (state == CAPTURE || idx == 3'd7) begin
          asm_r[{idx, 2'b00} +: 4] <= nibble;
          state <= CAPTURE;
          expect_idx <= idx - 3'd1;
          if (idx == 3'd0) begin
            value <= {asm_r[31:4], nibble};
            frame_valid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: randomized and directed checks of seg_scan_capture against a run-length reference model.
module tb_seg_scan_capture;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] an = 8'hFF;
  logic [6:0] seg = 7'h7F;
  logic [31:0] value;
  logic frame_valid, seq_err, seg_err;
  int checks = 0, failures = 0;
  int cyc = 0, last_fv = 0, prev_fv = 0;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [33:0] exp_q[$], got_q[$];
  logic [7:0] m_an;
  logic [6:0] m_seg;
  int m_run, m_exp;
  bit m_taken, m_cap;
  logic [3:0] m_dig [8];
  logic [31:0] m_value;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .value(value),
    .frame_valid(frame_valid), .seq_err(seq_err), .seg_err(seg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (frame_valid) begin
        got_q.push_back({2'd1, value});
        prev_fv = last_fv;
        last_fv = cyc;
      end
      if (seq_err) got_q.push_back({2'd2, 32'd0});
      if (seg_err) got_q.push_back({2'd3, 32'd0});
    end

  function automatic int dec(logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  // One accepted digit applied to the frame-assembly rules.
  task automatic model_accept(logic [7:0] a, logic [6:0] s);
    int k = -1;
    int d = dec(s);
    bit onehot = $countones(~a) == 1;
    for (int i = 0; i < 8; i++) if (!a[i]) k = i;
    if (!onehot || (m_cap && k != m_exp)) begin
      exp_q.push_back({2'd2, 32'd0});
      m_cap = 0;
    end else if (d < 0) begin
      exp_q.push_back({2'd3, 32'd0});
      m_cap = 0;
    end else if (m_cap || k == 7) begin
      m_dig[k] = 4'(d);
      m_cap = 1;
      m_exp = k - 1;
      if (k == 0) begin
        for (int i = 0; i < 8; i++) m_value[4*i +: 4] = m_dig[i];
        exp_q.push_back({2'd1, m_value});
        m_exp = 7;
      end
    end
  endtask

  // A digit counts once its inputs have held unchanged for S+1 clock edges.
  task automatic feed(logic [7:0] a, logic [6:0] s, int l);
    if ({a, s} != {m_an, m_seg}) begin
      if (a != m_an) m_taken = 0;
      m_run = 0;
      m_an = a;
      m_seg = s;
    end
    m_run += l;
    if (!m_taken && m_run >= S + 1 && a != 8'hFF) begin
      m_taken = 1;
      model_accept(a, s);
    end
  endtask

  task automatic drive(logic [7:0] a, logic [6:0] s, int l);
    if (l <= 0) return;
    feed(a, s, l);
    an = a;
    seg = s;
    repeat (l) begin @(posedge clk); #1; end
  endtask

  task automatic digit(logic [31:0] v, int k, int l);
    drive(~(8'b1 << k), pat[v[4*k +: 4]], l);
  endtask

  task automatic scan(logic [31:0] v, int dwell, int blank);
    for (int k = 7; k >= 0; k--) begin
      digit(v, k, dwell);
      drive(8'hFF, 7'h7F, blank);
    end
  endtask

  task automatic settle();
    drive(8'hFF, 7'h7F, S + 6);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    an = 8'hFF;
    seg = 7'h7F;
    repeat (n) begin @(posedge clk); #1; end
    m_an = 8'hFF; m_seg = 7'h7F; m_run = 0; m_taken = 0; m_cap = 0; m_exp = 7; m_value = '0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    exp_q.delete();
    got_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({value, frame_valid, seq_err, seg_err} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b%b%b want=0/000", value, frame_valid, seq_err, seg_err);
    end
    do_reset(1);
    settle();
    checks++;
    if (value !== 32'd0 || got_q.size() != 0) begin
      failures++;
      $display("FAIL reset_idle value=%h events=%0d want value=0 events=0", value, got_q.size());
    end
  endtask

  task automatic test_basic();
    int lat = -1;
    for (int k = 7; k >= 1; k--) digit(32'h12345678, k, 8);
    feed(8'hFE, pat[8], 8);
    an = 8'hFE;
    seg = pat[8];
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (frame_valid && lat < 0) lat = i;
    end
    checks++;
    if (lat != S + 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=%0d", lat, S + 2);
    end
    scan(32'h12345678, 8, 0);
    settle();
    checks++;
    if (last_fv - prev_fv != 64) begin
      failures++;
      $display("FAIL basic_period got=%0d want=64", last_fv - prev_fv);
    end
    checks++;
    if (value !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_value got=%h want=12345678", value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_glitch();
    scan(32'hCAFEF00D, 8, 0);
    for (int k = 7; k >= 0; k--)
      if (k == 3) begin
        digit(32'hCAFEF00D, 3, 5);
        drive(8'hF7, 7'h00, 2);
        digit(32'hCAFEF00D, 3, 1);
      end else digit(32'hCAFEF00D, k, 8);
    settle();
    checks++;
    if (value !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL glitch_value got=%h want=cafef00d", value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL glitch_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL glitch_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_seq_err();
    digit(32'h9ABCDEF0, 7, 8);
    digit(32'h9ABCDEF0, 6, 8);
    digit(32'h9ABCDEF0, 4, 8);
    settle();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'd2, 32'd0}) begin
      failures++;
      $display("FAIL seq_skip events=%0d first=%h want 1 seq_err event", got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
    scan(32'h0F1E2D3C, 8, 0);
    settle();
    checks++;
    if (value !== 32'h0F1E2D3C) begin
      failures++;
      $display("FAIL seq_recover_value got=%h want=0f1e2d3c", value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL seq_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL seq_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_seg_err();
    scan(32'h13572468, 8, 0);
    digit(32'hFFFFFFFF, 7, 8);
    digit(32'hFFFFFFFF, 6, 8);
    drive(8'hDF, 7'h7F, 8);
    digit(32'hFFFFFFFF, 4, 8);
    settle();
    checks++;
    if (value !== 32'h13572468) begin
      failures++;
      $display("FAIL seg_hold_value got=%h want=13572468", value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL seg_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL seg_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_blank();
    scan(32'hDEADBEEF, 7, 3);
    settle();
    checks++;
    if (value !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL blank_value got=%h want=deadbeef", value);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'd1, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL blank_events count=%0d first=%h want one frame", got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_mid_reset();
    for (int k = 7; k >= 2; k--) digit(32'h24681357, k, 8);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (value !== 32'd0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear value=%h fv=%b want 0/0", value, frame_valid);
    end
    do_reset(2);
    digit(32'h24681357, 1, 8);
    digit(32'h24681357, 0, 8);
    settle();
    checks++;
    if (got_q.size() != 0 || value !== 32'd0) begin
      failures++;
      $display("FAIL midreset_tail events=%0d value=%h want 0/0", got_q.size(), value);
    end
    scan(32'h24681357, 8, 0);
    settle();
    checks++;
    if (got_q.size() != 1 || value !== 32'h24681357) begin
      failures++;
      $display("FAIL midreset_frame events=%0d value=%h want 1/24681357", got_q.size(), value);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [31:0] v = $urandom;
      for (int k = 7; k >= 0; k--) begin
        int f = $urandom_range(0, 15);
        int dw = $urandom_range(S - 1, S + 4);
        if (f == 0) ;
        else if (f == 1) drive(~(8'b1 << k), 7'($urandom), dw);
        else if (f == 2) drive(8'($urandom), pat[v[4*k +: 4]], dw);
        else digit(v, k, dw);
        drive(8'hFF, 7'h7F, $urandom_range(0, 2));
      end
    end
    settle();
    checks++;
    if (value !== m_value) begin
      failures++;
      $display("FAIL random_value got=%h want=%h", value, m_value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_seq_err();
    test_seg_err();
    test_blank();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
